// File: rtl/mem_stage_req.sv
// mem_stage_req: memory-access pipeline stage between EX and WB.
// Issues data-memory accesses over a req/addr_ok/data_ok handshake with a
// single outstanding request, replicates store data across byte lanes,
// supports flush with in-flight cancellation and captures load data for WB.
// Optional feature macro: MEM_ALE_EN (misaligned-address detection, out_ale).
//
// state  | meaning
// IDLE   | no request outstanding; may issue data_req
// WAIT   | request accepted, waiting for data_data_ok
// DONE   | response received but WB stalled; load data held
// CANCEL | flushed while outstanding; drain and drop the response
module mem_stage_req #(
  parameter logic [31:0] PC_RESET = 32'h1c000000,
  parameter int          DEST_W   = 5,
  parameter int          OP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_result,
  input  logic [OP_W-1:0]   in_mem_op,
  input  logic              in_res_from_mem,
  input  logic              in_gr_we,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [31:0]       in_wdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_result,
  output logic [OP_W-1:0]   out_mem_op,
  output logic              out_res_from_mem,
  output logic              out_gr_we,
  output logic [DEST_W-1:0] out_dest,
`ifdef MEM_ALE_EN
  output logic              out_ale,
`endif
  output logic [31:0]       out_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [1:0] CANCEL = 2'd3;

  logic [1:0]  state;
  logic [31:0] hold_rdata;
  logic        is_mem, is_byte, is_half, is_word;
  logic        ale, req_raw, ready_go, load_payload;

  assign is_mem  = |in_mem_op;
  assign is_byte = in_mem_op[0] | in_mem_op[3] | in_mem_op[5];
  assign is_half = in_mem_op[1] | in_mem_op[4] | in_mem_op[6];
  assign is_word = in_mem_op[2] | in_mem_op[7];

`ifdef MEM_ALE_EN
  assign ale = (is_half & in_result[0]) | (is_word & |in_result[1:0]);
`else
  assign ale = 1'b0;
`endif

  // Access request before flush gating; used to spot an acceptance racing a flush.
  assign req_raw  = in_valid & is_mem & (state == IDLE) & ~ale;
  assign data_req = req_raw & ~flush;

  assign ready_go = (state != CANCEL) &
                    (~is_mem | ale | (state == WAIT & data_data_ok) | (state == DONE));
  assign in_ready = ~rst & ~flush & (state != CANCEL) & (~in_valid | (ready_go & out_ready));
  assign load_payload = in_valid & ready_go & out_ready;

  assign data_wr   = |in_mem_op[7:5];
  assign data_addr = in_result;

  // Access size, byte strobes and lane-replicated store data.
  always_comb begin
    data_size  = 2'd0;
    data_wstrb = 4'b0000;
    data_wdata = in_wdata;
    if (is_word)      data_size = 2'd2;
    else if (is_half) data_size = 2'd1;
    if (in_mem_op[5]) begin
      data_wstrb = 4'b0001 << in_result[1:0];
      data_wdata = {4{in_wdata[7:0]}};
    end else if (in_mem_op[6]) begin
      data_wstrb = 4'b0011 << in_result[1:0];
      data_wdata = {2{in_wdata[15:0]}};
    end else if (in_mem_op[7]) begin
      data_wstrb = 4'b1111;
    end
  end

  // Handshake state machine.
  // addr_ok seen together with a flush is treated as a possibly committed
  // access, so its response is drained in CANCEL rather than left dangling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            if (req_raw & data_addr_ok) state <= CANCEL;
          end else if (data_req & data_addr_ok) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            if (flush | out_ready) state <= IDLE;
            else                   state <= DONE;
          end else if (flush) begin
            state <= CANCEL;
          end
        end
        DONE: begin
          if (flush | out_ready) state <= IDLE;
        end
        CANCEL: begin
          if (data_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holds load data while WB is stalled after the response arrived.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_rdata <= 32'd0;
    end else if (state == WAIT && data_data_ok && !out_ready && !flush) begin
      hold_rdata <= data_rdata;
    end
  end

  // Output valid toward WB.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
    end else if (out_ready) begin
      out_valid <= in_valid & ready_go & (state != CANCEL);
    end
  end

  // Payload registers toward WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pc           <= PC_RESET;
      out_result       <= 32'd0;
      out_mem_op       <= '0;
      out_res_from_mem <= 1'b0;
      out_gr_we        <= 1'b0;
      out_dest         <= '0;
      out_rdata        <= 32'd0;
`ifdef MEM_ALE_EN
      out_ale          <= 1'b0;
`endif
    end else if (load_payload) begin
      out_pc           <= in_pc;
      out_result       <= in_result;
      out_mem_op       <= in_mem_op;
      out_res_from_mem <= in_res_from_mem;
      out_gr_we        <= in_gr_we;
      out_dest         <= in_dest;
`ifdef MEM_ALE_EN
      out_ale          <= ale;
`endif
      if (state == WAIT)      out_rdata <= data_rdata;
      else if (state == DONE) out_rdata <= hold_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage_req.sv
// Directed testbench for mem_stage_req; expected values are hand-computed.
// Build with MEM_ALE_EN defined to exercise the misaligned-access checks.
module tb_mem_stage_req;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] in_pc, in_result, in_wdata;
  logic [7:0]  in_mem_op;
  logic        in_res_from_mem, in_gr_we;
  logic [4:0]  in_dest;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] out_pc, out_result, out_rdata;
  logic [7:0]  out_mem_op;
  logic        out_res_from_mem, out_gr_we;
  logic [4:0]  out_dest;
`ifdef MEM_ALE_EN
  logic        out_ale;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage_req dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .in_pc(in_pc), .in_result(in_result), .in_mem_op(in_mem_op),
    .in_res_from_mem(in_res_from_mem), .in_gr_we(in_gr_we),
    .in_dest(in_dest), .in_wdata(in_wdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .out_pc(out_pc), .out_result(out_result), .out_mem_op(out_mem_op),
    .out_res_from_mem(out_res_from_mem), .out_gr_we(out_gr_we),
    .out_dest(out_dest),
`ifdef MEM_ALE_EN
    .out_ale(out_ale),
`endif
    .out_rdata(out_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [7:0] op, input logic [31:0] pc,
                          input logic [31:0] addr, input logic [4:0] dest);
    in_valid        = 1'b1;
    in_mem_op       = op;
    in_pc           = pc;
    in_result       = addr;
    in_dest         = dest;
    in_gr_we        = ~|op[7:5];
    in_res_from_mem = |op[4:0];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_pc = 0; in_result = 0; in_mem_op = 0; in_res_from_mem = 0;
    in_gr_we = 0; in_dest = 0; in_wdata = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pc", out_pc, 32'h1c000000);
    check_eq("rst_out_result", out_result, 0);
    check_eq("rst_out_rdata", out_rdata, 0);
    check_eq("rst_in_ready", in_ready, 0);
`ifdef MEM_ALE_EN
    check_eq("rst_out_ale", out_ale, 0);
`endif
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", in_ready, 1);

    // LW 0x1000: addr_ok cycle 0, data_ok cycle 2
    tick();
    drive_op(8'h04, 32'h1c000010, 32'h1000, 5'd4);
    data_addr_ok = 1'b1;
    @(negedge clk);
    check_eq("lw_req", data_req, 1);
    check_eq("lw_size", data_size, 2);
    check_eq("lw_wr", data_wr, 0);
    check_eq("lw_wstrb", data_wstrb, 0);
    check_eq("lw_addr", data_addr, 32'h1000);
    check_eq("lw_in_ready_c0", in_ready, 0);
    tick();
    data_addr_ok = 1'b0;
    @(negedge clk);
    check_eq("lw_req_c1", data_req, 0);
    check_eq("lw_in_ready_c1", in_ready, 0);
    check_eq("lw_out_valid_c1", out_valid, 0);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("lw_in_ready_c2", in_ready, 1);
    tick();
    in_valid = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    check_eq("lw_out_valid", out_valid, 1);
    check_eq("lw_out_rdata", out_rdata, 32'hDEADBEEF);
    check_eq("lw_out_pc", out_pc, 32'h1c000010);
    check_eq("lw_out_dest", out_dest, 4);
    check_eq("lw_out_rfm", out_res_from_mem, 1);
    tick();
    check_eq("lw_out_valid_drop", out_valid, 0);

    // Store encoding (no addr_ok, so the stage stays IDLE)
    in_wdata = 32'h12345678;
    drive_op(8'h20, 32'h1c000014, 32'h1003, 5'd0);
    #1;
    check_eq("sb_wstrb", data_wstrb, 4'b1000);
    check_eq("sb_wdata", data_wdata, 32'h78787878);
    check_eq("sb_size", data_size, 0);
    check_eq("sb_wr", data_wr, 1);
    drive_op(8'h40, 32'h1c000014, 32'h1002, 5'd0);
    #1;
    check_eq("sh_wstrb", data_wstrb, 4'b1100);
    check_eq("sh_wdata", data_wdata, 32'h56785678);
    check_eq("sh_size", data_size, 1);
    drive_op(8'h80, 32'h1c000014, 32'h1000, 5'd0);
    #1;
    check_eq("sw_wstrb", data_wstrb, 4'b1111);
    check_eq("sw_wdata", data_wdata, 32'h12345678);
    check_eq("sw_size", data_size, 2);
    drive_op(8'h40, 32'h1c000014, 32'h1003, 5'd0);
    #1;
    check_eq("sh_mis_wstrb", data_wstrb, 4'b1000);
`ifdef MEM_ALE_EN
    check_eq("sh_mis_req", data_req, 0);
`else
    check_eq("sh_mis_req", data_req, 1);
`endif
    in_valid = 1'b0; in_wdata = 0; in_mem_op = 0;
    tick();

    // LW with WB stalled: response held in DONE
    drive_op(8'h04, 32'h1c000020, 32'h2000, 5'd9);
    data_addr_ok = 1'b1; out_ready = 1'b0;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check_eq("stall_in_ready", in_ready, 0);
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_req", data_req, 0);
      check_eq("stall_out_valid", out_valid, 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_eq("release_out_valid", out_valid, 1);
    check_eq("release_out_rdata", out_rdata, 32'hCAFEF00D);
    check_eq("release_out_dest", out_dest, 9);
    tick();

    // Flush one cycle after addr_ok -> CANCEL, response dropped
    drive_op(8'h04, 32'h1c000030, 32'h3000, 5'd3);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    drive_op(8'h04, 32'h1c000034, 32'h4000, 5'd10);
    data_addr_ok = 1'b1;
    @(negedge clk);
    check_eq("cancel_req", data_req, 0);
    check_eq("cancel_in_ready", in_ready, 0);
    check_eq("cancel_out_valid", out_valid, 0);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check_eq("cancel_drain_req", data_req, 0);
    tick();
    data_data_ok = 1'b0; data_rdata = 0;
    check_eq("cancel_out_valid_after", out_valid, 0);
    data_addr_ok = 1'b1;
    @(negedge clk);
    check_eq("post_cancel_req", data_req, 1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000ABCD;
    tick();
    in_valid = 1'b0; data_data_ok = 1'b0; data_rdata = 0;
    check_eq("post_cancel_out_valid", out_valid, 1);
    check_eq("post_cancel_rdata", out_rdata, 32'h0000ABCD);
    check_eq("post_cancel_result", out_result, 32'h4000);
    tick();

    // Non-memory ALU op passes in one cycle
    drive_op(8'h00, 32'h1c000040, 32'h000055AA, 5'd7);
    @(negedge clk);
    check_eq("alu_req", data_req, 0);
    check_eq("alu_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_eq("alu_out_valid", out_valid, 1);
    check_eq("alu_out_result", out_result, 32'h000055AA);
    check_eq("alu_out_dest", out_dest, 7);
    check_eq("alu_out_gr_we", out_gr_we, 1);
    check_eq("alu_out_rfm", out_res_from_mem, 0);
    tick();

    // Reset mid-transaction returns to IDLE
    drive_op(8'h04, 32'h1c000050, 32'h5000, 5'd5);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_pc", out_pc, 32'h1c000000);
    @(negedge clk);
    check_eq("midrst_req", data_req, 1);
    in_valid = 1'b0;
    tick();

`ifdef MEM_ALE_EN
    // Misaligned LH: no request, out_ale flagged
    drive_op(8'h02, 32'h1c000060, 32'h1001, 5'd6);
    @(negedge clk);
    check_eq("ale_req", data_req, 0);
    check_eq("ale_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_eq("ale_out_valid", out_valid, 1);
    check_eq("ale_out_ale", out_ale, 1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
